// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, data width and baud divider helper for the UART receive path
package uart_pkg;

  localparam int DataBits = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Rounded to nearest so odd clock/baud ratios land on the closest tick period.
  function automatic int calc_divider(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator with synchronous restart
module uart_baud_tick #(
  parameter int Divider = 78
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CntW = (Divider > 1) ? $clog2(Divider) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Divider - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_o = !restart_i && (cnt_q == CntMax);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART receiver: 2-flop sync, 3-sample vote, 1-entry output register
// Define UART_RX_PARITY_EN for 8E1 framing with a live parity_err_o; default is 8N1.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 12_000_000,
  parameter int BaudRate       = 9_600,
  parameter int Oversample     = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  output logic [DataBits-1:0] data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                frame_err_o,
  output logic                overrun_o,
  output logic                parity_err_o
);

  localparam int Divider = calc_divider(ClockFrequency, BaudRate, Oversample);
  localparam int TickW   = $clog2(Oversample);
  localparam int BitW    = $clog2(DataBits);
  localparam logic [TickW-1:0] TSamp0  = TickW'(Oversample / 2 - 1);
  localparam logic [TickW-1:0] TSamp1  = TickW'(Oversample / 2);
  localparam logic [TickW-1:0] TSamp2  = TickW'(Oversample / 2 + 1);
  localparam logic [TickW-1:0] TLast   = TickW'(Oversample - 1);
  localparam logic [BitW-1:0]  LastBit = BitW'(DataBits - 1);

  if (Oversample < 8 || (Oversample % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_deserializer: Oversample must be even and >= 8");
  end

  logic [1:0]          rx_sync_q;
  rx_state_e           state_q;
  logic [TickW-1:0]    t_q;
  logic [BitW-1:0]     bit_cnt_q;
  logic [1:0]          samp_q;
  logic                bit_q;
  logic [DataBits-1:0] shift_q;
  logic [DataBits-1:0] data_q;
  logic                armed_q;
  logic                pending_q;
  logic                valid_q;
  logic                frame_err_q;
  logic                overrun_q;
  logic                rx_s;
  logic                tick;
  logic                restart;
  logic                maj;
  logic                t_last;
  logic                t_vote;
  logic                byte_ok;
`ifdef UART_RX_PARITY_EN
  logic                par_q;
  logic                parity_err_q;
`endif

  assign rx_s    = rx_sync_q[1];
  assign restart = (state_q == IDLE) && armed_q && !rx_s;
  assign maj     = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);
  assign t_last  = tick && (t_q == TLast);
  assign t_vote  = tick && (t_q == TSamp2);
`ifdef UART_RX_PARITY_EN
  assign byte_ok = maj && !(^{shift_q, par_q});
`else
  assign byte_ok = maj;
`endif

  uart_baud_tick #(
    .Divider(Divider)
  ) u_baud_tick (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .restart_i(restart),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q   <= 2'b11;
      state_q     <= IDLE;
      t_q         <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      bit_q       <= 1'b1;
      shift_q     <= '0;
      data_q      <= '0;
      armed_q     <= 1'b0;
      pending_q   <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_sync_q   <= {rx_sync_q[0], rx_i};
      pending_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      // A completed byte loads one cycle after the stop vote; a same-cycle accept frees the slot.
      if (pending_q) begin
        if (!valid_q || ready_i) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end

      if (tick) begin
        t_q <= (t_q == TLast) ? '0 : t_q + 1'b1;
        if (t_q == TSamp0 || t_q == TSamp1) begin
          samp_q <= {samp_q[0], rx_s};
        end
        if (t_q == TSamp2) begin
          bit_q <= maj;
        end
      end

      case (state_q)
        IDLE: begin
          if (!armed_q) begin
            armed_q <= rx_s;
          end else if (!rx_s) begin
            state_q <= START;
            t_q     <= '0;
          end
        end
        START: begin
          if (t_last) begin
            state_q   <= bit_q ? IDLE : DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (t_last) begin
            shift_q   <= {bit_q, shift_q[DataBits-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (t_last) begin
            par_q   <= bit_q;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          // Leave mid-stop so a start edge inside a short stop bit is still caught;
          // a low stop (break) disarms until the line is seen high again.
          if (t_vote) begin
            state_q     <= IDLE;
            armed_q     <= maj;
            frame_err_q <= !maj;
            pending_q   <= byte_ok;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= ^{shift_q, par_q};
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - directed self-checking bench for uart_rx_deserializer
module tb_uart_rx_deserializer;
  import uart_pkg::*;

  localparam int Baud  = 9_600;
  localparam int Os    = 16;
  localparam int Div   = 32;
  localparam int Clk   = Baud * Os * Div;
  localparam int Bit   = Div * Os;
  localparam int Short = Bit * 6 / 10;
`ifdef UART_RX_PARITY_EN
  localparam bit HasParity = 1'b1;
`else
  localparam bit HasParity = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  int checks = 0;
  int errors = 0;
  int got_n = 0;
  int valid_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] got_mem [0:63];
  int n0, vc0, fe0, ov0, pe0;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .ClockFrequency(Clk),
    .BaudRate      (Baud),
    .Oversample    (Os)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .parity_err_o(parity_err_o)
  );

  always @(negedge clk) begin
    if (valid_o && ready_i) begin
      got_mem[got_n % 64] = data_o;
      got_n++;
    end
    if (valid_o) valid_cyc++;
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
    if (parity_err_o) pe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_i = v;
    step(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int stop_len);
    drive(1'b0, Bit);
    for (int i = 0; i < 8; i++) drive(b[i], Bit);
    if (HasParity) drive(par, Bit);
    drive(stop, stop_len);
    rx_i = 1'b1;
  endtask

  task automatic mark();
    n0  = got_n;
    vc0 = valid_cyc;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    pe0 = pe_cnt;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst_ni  = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    step(4);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_data", 32'(data_o), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err_o), 32'd0);
    check_eq("rst_overrun", 32'(overrun_o), 32'd0);
    check_eq("rst_parity_err", 32'(parity_err_o), 32'd0);
    check_eq("div_default", 32'(calc_divider(12_000_000, 9_600, 16)), 32'd78);
    check_eq("div_round_up", 32'(calc_divider(12_000_000, 115_200, 16)), 32'd7);
    check_eq("div_round_down", 32'(calc_divider(12_000_000, 19_200, 16)), 32'd39);
    rst_ni = 1'b1;
    step(2 * Bit);

    mark();
    send_frame(8'hA5, ^8'hA5, 1'b1, Bit);
    step(Bit);
    check_eq("a5_count", 32'(got_n - n0), 32'd1);
    check_eq("a5_data", 32'(got_mem[n0 % 64]), 32'hA5);
    check_eq("a5_valid_cycles", 32'(valid_cyc - vc0), 32'd1);
    check_eq("a5_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check_eq("a5_overrun", 32'(ov_cnt - ov0), 32'd0);

    mark();
    drive(1'b0, 3 * Div);
    drive(1'b1, 2 * Bit);
    check_eq("glitch_count", 32'(got_n - n0), 32'd0);
    check_eq("glitch_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check_eq("glitch_valid", 32'(valid_o), 32'd0);

    mark();
    send_frame(8'h3C, ^8'h3C, 1'b0, Bit);
    step(Bit);
    check_eq("badstop_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check_eq("badstop_count", 32'(got_n - n0), 32'd0);
    check_eq("badstop_valid", 32'(valid_o), 32'd0);

    mark();
    ready_i = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1, Bit);
    send_frame(8'h22, ^8'h22, 1'b1, Bit);
    step(Bit);
    check_eq("ovr_valid_held", 32'(valid_o), 32'd1);
    check_eq("ovr_data_held", 32'(data_o), 32'h11);
    check_eq("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    check_eq("ovr_frame_err", 32'(fe_cnt - fe0), 32'd0);
    ready_i = 1'b1;
    step(2);
    check_eq("ovr_valid_drop", 32'(valid_o), 32'd0);
    check_eq("ovr_count", 32'(got_n - n0), 32'd1);
    check_eq("ovr_first_byte", 32'(got_mem[n0 % 64]), 32'h11);

    mark();
    send_frame(8'h00, ^8'h00, 1'b1, Short);
    send_frame(8'hFF, ^8'hFF, 1'b1, Short);
    send_frame(8'h80, ^8'h80, 1'b1, Short);
    step(2 * Bit);
    check_eq("b2b_count", 32'(got_n - n0), 32'd3);
    check_eq("b2b_byte0", 32'(got_mem[n0 % 64]), 32'h00);
    check_eq("b2b_byte1", 32'(got_mem[(n0 + 1) % 64]), 32'hFF);
    check_eq("b2b_byte2", 32'(got_mem[(n0 + 2) % 64]), 32'h80);
    check_eq("b2b_frame_err", 32'(fe_cnt - fe0), 32'd0);

    mark();
    drive(1'b0, Bit);
    for (int i = 0; i < 4; i++) drive(((8'h5A >> i) & 8'h01) != 8'h00, Bit);
    drive(1'b1, Bit / 2);
    rst_ni = 1'b0;
    rx_i   = 1'b1;
    step(3);
    check_eq("midrst_data", 32'(data_o), 32'd0);
    check_eq("midrst_valid", 32'(valid_o), 32'd0);
    rst_ni = 1'b1;
    step(2 * Bit);
    send_frame(8'h01, ^8'h01, 1'b1, Bit);
    step(Bit);
    check_eq("midrst_count", 32'(got_n - n0), 32'd1);
    check_eq("midrst_byte", 32'(got_mem[n0 % 64]), 32'h01);
    check_eq("midrst_frame_err", 32'(fe_cnt - fe0), 32'd0);

`ifdef UART_RX_PARITY_EN
    mark();
    send_frame(8'h01, 1'b0, 1'b1, Bit);
    step(Bit);
    check_eq("par_bad_pulse", 32'(pe_cnt - pe0), 32'd1);
    check_eq("par_bad_count", 32'(got_n - n0), 32'd0);
    check_eq("par_bad_frame_err", 32'(fe_cnt - fe0), 32'd0);
    mark();
    send_frame(8'h03, 1'b0, 1'b1, Bit);
    step(Bit);
    check_eq("par_good_count", 32'(got_n - n0), 32'd1);
    check_eq("par_good_byte", 32'(got_mem[n0 % 64]), 32'h03);
    check_eq("par_good_pulse", 32'(pe_cnt - pe0), 32'd0);
`else
    check_eq("parity_err_never", 32'(pe_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
